// File: rtl/seq_lshift.sv
// seq_lshift: multi-cycle variable left shifter, one bit position per clock.
// Ready/valid on both sides, one request in flight, and a sticky flag that
// records whether any set bit was pushed out past the MSB.
module seq_lshift #(
  parameter int WIDTH = 8,
  parameter int AMTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMTW-1:0]  in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Wide enough to hold both in_amt and WIDTH, so the saturation compare
  // stays unsigned and correct whatever AMTW is.
  localparam int CMPW = (AMTW > 31) ? (AMTW + 1) : 32;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_nxt_s;
  logic [AMTW-1:0]  cnt_r;
  logic [AMTW-1:0]  cnt_nxt_s;
  logic             ovf_r;
  logic             ovf_nxt_s;
  logic [CMPW-1:0]  amt_ext_s;
  logic             amt_sat_s;
  logic             amt_zero_s;

  assign amt_ext_s  = CMPW'(in_amt);
  assign amt_sat_s  = (amt_ext_s >= CMPW'(WIDTH));
  assign amt_zero_s = (in_amt == {AMTW{1'b0}});

  // Outputs come straight from state/datapath registers; no comb logic on data.
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign out_data  = data_r;
  assign out_ovf   = ovf_r;

  // Next-state and datapath update for the accept / shift / hand-off sequence.
  always_comb begin
    state_nxt_s = state_r;
    data_nxt_s  = data_r;
    cnt_nxt_s   = cnt_r;
    ovf_nxt_s   = ovf_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (amt_zero_s) begin
            data_nxt_s  = in_data;
            ovf_nxt_s   = 1'b0;
            state_nxt_s = DONE;
          end else if (amt_sat_s) begin
            // Everything leaves through the MSB at once; no iteration needed.
            data_nxt_s  = {WIDTH{1'b0}};
            ovf_nxt_s   = (in_data != {WIDTH{1'b0}});
            state_nxt_s = DONE;
          end else begin
            data_nxt_s  = in_data;
            ovf_nxt_s   = 1'b0;
            cnt_nxt_s   = in_amt;
            state_nxt_s = SHIFT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        ovf_nxt_s  = ovf_r | data_r[WIDTH-1];
        data_nxt_s = {data_r[WIDTH-2:0], 1'b0};
        cnt_nxt_s  = cnt_r - {{(AMTW-1){1'b0}}, 1'b1};
        if (cnt_r == {{(AMTW-1){1'b0}}, 1'b1}) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE: begin
        // Result (data_r, ovf_r) is left in place after the hand-off.
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        data_nxt_s  = {WIDTH{1'b0}};
        cnt_nxt_s   = {AMTW{1'b0}};
        ovf_nxt_s   = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      data_r  <= {WIDTH{1'b0}};
      cnt_r   <= {AMTW{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      data_r  <= data_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

endmodule

// File: tb/tb_seq_lshift.sv
// Directed self-checking bench for seq_lshift (WIDTH=8, AMTW=8).
module tb_seq_lshift;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_ovf;
  logic       busy;

  int total = 0;
  int bad   = 0;

  seq_lshift #(.WIDTH(8), .AMTW(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full transaction with out_ready high; checks latency and result.
  task automatic run(input string tag, input logic [7:0] d, input logic [7:0] a,
                     input logic [7:0] ed, input logic eo, input int elat);
    int lat;
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready, 1);
    in_valid = 1'b1; in_data = d; in_amt = a; out_ready = 1'b1;
    @(posedge clk);
    #1;
    // Later input changes must not affect the result.
    in_valid = 1'b0; in_data = 8'hee; in_amt = 8'h03;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_ovf"}, out_ovf, eo);
    @(posedge clk);
  endtask

  int accepts;
  int busy_accepts;
  int waitc;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_amt = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_busy", busy, 0);

    // Walking one through every position.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] one;
      one = 8'h01;
      run($sformatf("walk%0d", i), 8'h01, 8'(i), one << i, 1'b0, i + 1);
    end

    run("ovf_a5_1", 8'ha5, 8'd1, 8'h4a, 1'b1, 2);
    run("ovf_25_3", 8'h25, 8'd3, 8'h28, 1'b1, 4);
    run("ovf_05_4", 8'h05, 8'd4, 8'h50, 1'b0, 5);
    run("sat_a5_8", 8'ha5, 8'd8, 8'h00, 1'b1, 1);
    run("sat_00_ff", 8'h00, 8'hff, 8'h00, 1'b0, 1);

    // Backpressure: hold DONE for 5 cycles while other requests knock.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h80; in_amt = 8'd0; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", i), out_valid, 1);
      chk($sformatf("bp_data%0d", i), out_data, 8'h80);
      chk($sformatf("bp_ready%0d", i), in_ready, 0);
      in_valid = i[0]; in_data = 8'h55; in_amt = 8'd1;
    end
    @(negedge clk);
    chk("bp_hold_data", out_data, 8'h80);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_ready", in_ready, 1);
    chk("bp_after_valid", out_valid, 0);
    chk("bp_after_data", out_data, 8'h80);

    // Reset during the third SHIFT cycle.
    in_valid = 1'b1; in_data = 8'h01; in_amt = 8'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rm_busy_pre", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rm_in_ready", in_ready, 1);
    chk("rm_out_valid", out_valid, 0);
    chk("rm_out_data", out_data, 0);
    chk("rm_busy", busy, 0);
    reset = 1'b0;
    run("rm_after", 8'h01, 8'd1, 8'h02, 1'b0, 2);

    // Back-to-back with in_valid held high.
    accepts = 0; busy_accepts = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h81; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [7:0] amts [3];
      logic [7:0] eds [3];
      logic       eos [3];
      amts = '{8'd2, 8'd0, 8'd9};
      eds  = '{8'h04, 8'h81, 8'h00};
      eos  = '{1'b1, 1'b0, 1'b1};
      waitc = 0;
      while (!in_ready && waitc < 40) begin
        @(negedge clk);
        waitc++;
      end
      in_amt = amts[k];
      accepts++;
      if (busy) busy_accepts++;
      waitc = 0;
      do begin
        @(negedge clk);
        waitc++;
        if (in_ready && busy) busy_accepts++;
      end while (!out_valid && waitc < 40);
      chk($sformatf("b2b%0d_valid", k), out_valid, 1);
      chk($sformatf("b2b%0d_data", k), out_data, eds[k]);
      chk($sformatf("b2b%0d_ovf", k), out_ovf, eos[k]);
      if (k == 2) in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("b2b%0d_ready", k), in_ready, 1);
    end
    chk("b2b_accepts", accepts, 3);
    chk("b2b_busy_accepts", busy_accepts, 0);
    @(negedge clk);
    chk("b2b_idle_end", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
